// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the control unit and the iterative multiply/divide sequencer.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic             illegal;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, illegal, result
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, illegal, result
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULH/DIV/REM: shift-add multiplier and restoring divider, one bit per clock.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [3:0] OP_MUL  = 4'b0111;
   localparam logic [3:0] OP_MULH = 4'b1000;
   localparam logic [3:0] OP_DIV  = 4'b1001;
   localparam logic [3:0] OP_REM  = 4'b1010;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH:0]   hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             ill_q, ill_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             accept;

   function automatic logic is_legal(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // {hi,lo} is the double-width product; the multiplier bits drain out of lo's LSB.
   function automatic logic [2*WIDTH:0] mul_step(input logic [WIDTH:0] hi,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] m);
      logic [WIDTH:0] sum;
      sum = hi + (lo[0] ? {1'b0, m} : '0);
      return {1'b0, sum[WIDTH:1], sum[0], lo[WIDTH-1:1]};
   endfunction

   // hi holds the partial remainder, lo shifts dividend bits out and quotient bits in.
   function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0] hi,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] d);
      logic [WIDTH:0] shifted;
      logic [WIDTH:0] diff;
      logic           ge;
      shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
      ge      = shifted >= {1'b0, d};
      diff    = shifted - {1'b0, d};
      return {(ge ? diff : shifted), lo[WIDTH-2:0], ge};
   endfunction

   assign accept = bus.start && !bus.flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_legal(bus.op) && !(is_div(bus.op) && (bus.b == '0))) state_d = S_RUN;
               else                                                         state_d = S_FINISH;
            end
         end
         S_RUN: begin
            if (bus.flush)                       state_d = S_IDLE;
            else if (cnt_q == CW'(WIDTH - 1))    state_d = S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      op_d   = op_q;
      opnd_d = opnd_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      ill_d  = 1'b0;
      res_d  = res_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d   = bus.op;
               opnd_d = bus.b;
               lo_d   = bus.a;
               hi_d   = '0;
               cnt_d  = '0;
            end
         end
         S_RUN: begin
            if (!bus.flush) begin
               if (is_div(op_q)) {hi_d, lo_d} = div_step(hi_q, lo_q, opnd_q);
               else              {hi_d, lo_d} = mul_step(hi_q, lo_q, opnd_q);
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FINISH: begin
            if (!bus.flush) begin
               done_d = 1'b1;
               ill_d  = !is_legal(op_q);
               case (op_q)
                  OP_MUL:  res_d = lo_q;
                  OP_MULH: res_d = hi_q[WIDTH-1:0];
                  OP_DIV:  res_d = (opnd_q == '0) ? '1 : lo_q;
                  // Divide-by-zero never iterates, so lo still holds the dividend.
                  OP_REM:  res_d = (opnd_q == '0) ? lo_q : hi_q[WIDTH-1:0];
                  default: res_d = '0;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.busy    = (state_q != S_IDLE);
      bus.done    = done_q;
      bus.illegal = ill_q;
      bus.result  = res_q;
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: transaction-level reference model, per-cycle compare, directed literal checks.
module tb_muldiv_sequencer;
   localparam int W = 32;
   localparam logic [3:0] MUL = 4'b0111, MULH = 4'b1000, DIV = 4'b1001, REM = 4'b1010;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(W)) bus ();
   muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors = 0;
   int miscompares = 0;

   // Reference model: an op is a (result, illegal, latency) triple; busy lasts latency cycles.
   logic         m_busy = 1'b0, m_done = 1'b0, m_ill = 1'b0;
   logic [W-1:0] m_res = '0, p_res = '0;
   logic         p_ill = 1'b0;
   int           m_cnt = 0;
   logic [W-1:0] n_res;
   logic         n_ill;
   int           n_lat;

   function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ill, output int lat);
      logic [2*W-1:0] p;
      p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      ill = 1'b0;
      lat = W + 1;
      case (op)
         MUL:  r = p[W-1:0];
         MULH: r = p[2*W-1:W];
         DIV:  if (b == '0) begin r = '1; lat = 1; end else r = a / b;
         REM:  if (b == '0) begin r = a;  lat = 1; end else r = a % b;
         default: begin r = '0; ill = 1'b1; lat = 1; end
      endcase
   endfunction

   always_comb ref_op(bus.op, bus.a, bus.b, n_res, n_ill, n_lat);

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_ill <= 1'b0; m_res <= '0; m_cnt <= 0;
      end else begin
         m_done <= 1'b0;
         m_ill  <= 1'b0;
         if (m_busy) begin
            if (bus.flush) m_busy <= 1'b0;
            else if (m_cnt == 1) begin
               m_busy <= 1'b0; m_done <= 1'b1; m_ill <= p_ill; m_res <= p_res;
            end else m_cnt <= m_cnt - 1;
         end else if (bus.start && !bus.flush) begin
            m_busy <= 1'b1; m_cnt <= n_lat; p_res <= n_res; p_ill <= n_ill;
         end
      end
   end

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input logic exp_i, input int exp_lat, input bit intrude);
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom_range(0, 15));
      lat = 0;
      while (!bus.done && lat < 100) begin
         bus.start = intrude && (lat == 5);
         if (bus.start) begin bus.op = MUL; bus.a = 2; bus.b = 3; end
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      chk("latency", W'(lat), W'(exp_lat));
      chk("result_lit", bus.result, exp_r);
      chk("illegal_lit", {{(W-1){1'b0}}, bus.illegal}, {{(W-1){1'b0}}, exp_i});
   endtask

   task automatic abort_op(input bit use_reset, input logic [W-1:0] exp_r);
      int dn;
      @(negedge clk);
      bus.start = 1'b1; bus.op = MUL; bus.a = 11; bus.b = 13;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      if (use_reset) reset = 1'b1; else bus.flush = 1'b1;
      @(negedge clk);
      reset = 1'b0; bus.flush = 1'b0;
      chk(use_reset ? "busy_after_reset" : "busy_after_flush", {{(W-1){1'b0}}, bus.busy}, '0);
      chk(use_reset ? "result_after_reset" : "result_after_flush", bus.result, exp_r);
      dn = 0;
      repeat (40) begin @(negedge clk); if (bus.done) dn++; end
      chk("no_done_after_abort", W'(dn), '0);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      fork
         forever begin
            @(negedge clk);
            chk("busy", {{(W-1){1'b0}}, bus.busy}, {{(W-1){1'b0}}, m_busy});
            chk("done", {{(W-1){1'b0}}, bus.done}, {{(W-1){1'b0}}, m_done});
            chk("illegal", {{(W-1){1'b0}}, bus.illegal}, {{(W-1){1'b0}}, m_ill});
            chk("result", bus.result, m_res);
         end
      join_none
      repeat (2) @(negedge clk);
      chk("reset_busy", {{(W-1){1'b0}}, bus.busy}, '0);
      chk("reset_done", {{(W-1){1'b0}}, bus.done}, '0);
      chk("reset_result", bus.result, '0);
      reset = 1'b0;

      do_op(MUL, 7, 6, 42, 1'b0, 33, 1'b0);
      do_op(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
      do_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, 1'b0);
      do_op(DIV, 100, 7, 14, 1'b0, 33, 1'b0);
      do_op(REM, 100, 7, 2, 1'b0, 33, 1'b0);
      do_op(DIV, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
      do_op(DIV, 5, 0, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
      do_op(REM, 5, 0, 5, 1'b0, 1, 1'b0);
      do_op(4'b0010, 9, 9, 0, 1'b1, 1, 1'b0);
      do_op(DIV, 100, 7, 14, 1'b0, 33, 1'b1);

      abort_op(1'b1, '0);
      do_op(MUL, 3, 5, 15, 1'b0, 33, 1'b0);
      abort_op(1'b0, 15);
      do_op(MUL, 9, 9, 81, 1'b0, 33, 1'b0);

      // Flush beats start in IDLE.
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = MUL;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_blocks_start", {{(W-1){1'b0}}, bus.busy}, '0);

      repeat (3000) begin
         @(negedge clk);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 63) == 0);
         reset     = ($urandom_range(0, 511) == 0);
         case ($urandom_range(0, 4))
            0: bus.op = MUL;
            1: bus.op = MULH;
            2: bus.op = DIV;
            3: bus.op = REM;
            default: bus.op = 4'($urandom_range(0, 15));
         endcase
         bus.a = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
         case ($urandom_range(0, 7))
            0: bus.b = '0;
            1: bus.b = '1;
            2: bus.b = W'($urandom_range(1, 15));
            default: bus.b = $urandom;
         endcase
      end
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0; reset = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
